// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Scoreboard entries carry a fixed-width rd so the struct needs no parameters.
package pipe_pkg;

  localparam int TRK_RD_W = 8;

  localparam logic [TRK_RD_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic                is_load;
    logic [TRK_RD_W-1:0] rd;
  } trk_entry_t;

  function automatic int fwd_sel_w(input int n_trk);
    return $clog2(n_trk + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Used for the stall and redirect performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  // count enabled cycles, hold at the top value
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and redirect control for the in-order pipeline.
// A destination scoreboard feeds forwarding selects and load-use stalls.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter  int REG_AW     = 5,
  parameter  int N_SRC      = 2,
  parameter  int N_TRK      = 3,
  parameter  int LOAD_AVAIL = 2,
  parameter  int CNT_W      = 32,
  localparam int SELW       = fwd_sel_w(N_TRK)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    id_valid_i,
  input  logic [N_SRC*REG_AW-1:0] id_rs_i,
  input  logic [N_SRC-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]       id_rd_i,
  input  logic                    id_reg_write_i,
  input  logic                    id_is_load_i,
  input  logic                    redirect_i,
  input  logic                    hold_i,
  output logic                    stall_o,
  output logic                    flush_o,
  output logic [N_SRC*SELW-1:0]   fwd_sel_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  trk_entry_t          trk [N_TRK];
  logic [N_TRK-1:0]    live;
  logic [TRK_RD_W-1:0] rs;
  logic                hit;
  logic                hazard;
  logic [N_SRC*SELW-1:0] sel;
  logic                issue;

  // an entry can forward only if it really writes a nonzero register
  always_comb begin
    live = '0;
    for (int k = 0; k < N_TRK; k++) begin
      live[k] = trk[k].valid & trk[k].wen & (trk[k].rd != REG_ZERO);
    end
  end

  // youngest-first search per operand; load too young means stall
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    rs     = REG_ZERO;
    hit    = 1'b0;
    for (int j = 0; j < N_SRC; j++) begin
      rs  = TRK_RD_W'(id_rs_i[j*REG_AW +: REG_AW]);
      hit = 1'b0;
      if (id_rs_used_i[j] && (rs != REG_ZERO)) begin
        for (int k = 0; k < N_TRK; k++) begin
          if (!hit && live[k] && (trk[k].rd == rs)) begin
            hit = 1'b1;
            sel[j*SELW +: SELW] = SELW'(k + 1);
            if (trk[k].is_load && (k < LOAD_AVAIL)) begin
              hazard = 1'b1;
            end
          end
        end
      end
    end
  end

  assign fwd_sel_o = sel;
  assign stall_o   = reset_i & id_valid_i & hazard
                   & ~redirect_i & ~hold_i;
  assign flush_o   = reset_i & redirect_i & ~hold_i;
  assign issue     = id_valid_i & ~stall_o & ~redirect_i;

  // shift the scoreboard unless memory holds the pipe
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < N_TRK; k++) begin
        trk[k] <= '0;
      end
    end else if (!hold_i) begin
      for (int k = N_TRK - 1; k > 0; k--) begin
        trk[k] <= trk[k-1];
      end
      if (issue) begin
        trk[0] <= '{valid:   1'b1,
                    wen:     id_reg_write_i,
                    is_load: id_is_load_i,
                    rd:      TRK_RD_W'(id_rd_i)};
      end else begin
        trk[0] <= '0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (stall_o),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (flush_o),
    .cnt_o   (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: driver predicts from an instruction history model,
// monitor compares both a 32-bit and a 4-bit counter instance.
module tb_pipe_hazard_unit;

  typedef struct {
    bit v;
    bit w;
    bit ld;
    int rd;
  } ins_t;

  typedef struct {
    bit     stall;
    bit     flush;
    int     sel0;
    int     sel1;
    longint sc;
    longint fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_wen = 1'b0;
  logic        id_ld = 1'b0;
  logic        redir = 1'b0;
  logic        hold = 1'b0;

  logic        stall_a, flush_a, stall_b, flush_b;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] scnt_a, fcnt_a;
  logic [3:0]  scnt_b, fcnt_b;

  exp_t   q[$];
  ins_t   hist[$];
  longint n_stall = 0;
  longint n_flush = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk_i(clk), .reset_i(rst_n), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rs_used_i(id_used), .id_rd_i(id_rd),
    .id_reg_write_i(id_wen), .id_is_load_i(id_ld),
    .redirect_i(redir), .hold_i(hold),
    .stall_o(stall_a), .flush_o(flush_a), .fwd_sel_o(sel_a),
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
  );

  pipe_hazard_unit #(.CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(rst_n), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rs_used_i(id_used), .id_rd_i(id_rd),
    .id_reg_write_i(id_wen), .id_is_load_i(id_ld),
    .redirect_i(redir), .hold_i(hold),
    .stall_o(stall_b), .flush_o(flush_b), .fwd_sel_o(sel_b),
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
  );

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, act, want, $time);
    end
  endtask

  function automatic longint sat15(input longint x);
    return (x > 15) ? 15 : x;
  endfunction

  // one decode cycle: drive, predict, advance the history model
  task automatic step(input bit v, input int rs0, input int rs1,
                      input bit [1:0] used, input int rd, input bit w,
                      input bit ld, input bit rdr, input bit hld,
                      input bit rst);
    exp_t e;
    bit   haz;
    int   rs;
    int   s;
    @(negedge clk);
    id_valid = v;
    id_rs    = {5'(rs1), 5'(rs0)};
    id_used  = used;
    id_rd    = 5'(rd);
    id_wen   = w;
    id_ld    = ld;
    redir    = rdr;
    hold     = hld;
    rst_n    = !rst;
    if (rst) begin
      hist.delete();
      n_stall = 0;
      n_flush = 0;
    end
    haz = 0;
    e.sel0 = 0;
    e.sel1 = 0;
    for (int j = 0; j < 2; j++) begin
      rs = (j == 0) ? rs0 : rs1;
      s  = 0;
      if (used[j] && rs != 0) begin
        for (int k = 0; k < hist.size() && k < 3; k++) begin
          if (hist[k].v && hist[k].w && hist[k].rd == rs) begin
            s = k + 1;
            if (hist[k].ld && k < 2) haz = 1;
            break;
          end
        end
      end
      if (j == 0) e.sel0 = s;
      else e.sel1 = s;
    end
    e.stall = v && haz && !rdr && !hld && !rst;
    e.flush = rdr && !hld && !rst;
    e.sc    = n_stall;
    e.fc    = n_flush;
    q.push_back(e);
    if (!rst && !hld) begin
      if (v && !e.stall && !rdr) hist.push_front('{1, w, ld, rd});
      else hist.push_front('{0, 0, 0, 0});
      if (hist.size() > 3) void'(hist.pop_back());
      n_stall += e.stall;
      n_flush += e.flush;
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic use1(input int r, input bit rdr, input bit hld,
                      input bit rst);
    step(1, r, 0, 2'b01, 20, 1, 0, rdr, hld, rst);
  endtask

  task automatic wr(input int r, input bit ld);
    step(1, 0, 0, 2'b00, r, 1, ld, 0, 0, 0);
  endtask

  // compare whatever the driver predicted for this cycle
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 64'(stall_a), 64'(e.stall));
      chk("flush", 64'(flush_a), 64'(e.flush));
      chk("sel0", 64'(sel_a[1:0]), 64'(e.sel0));
      chk("sel1", 64'(sel_a[3:2]), 64'(e.sel1));
      chk("stall_cnt", 64'(scnt_a), 64'(e.sc));
      chk("flush_cnt", 64'(fcnt_a), 64'(e.fc));
      chk("stall4", 64'(stall_b), 64'(e.stall));
      chk("sel4", 64'(sel_b), 64'({2'(e.sel1), 2'(e.sel0)}));
      chk("stall_cnt4", 64'(scnt_b), 64'(sat15(e.sc)));
      chk("flush_cnt4", 64'(fcnt_b), 64'(sat15(e.fc)));
    end
  end

  initial begin
    step(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    nop();
    // ALU back-to-back
    step(1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
    step(1, 5, 3, 2'b11, 8, 1, 0, 0, 0, 0);
    nop(); nop(); nop();
    // load-use: two stalls then WB forward
    wr(6, 1);
    use1(6, 0, 0, 0); use1(6, 0, 0, 0); use1(6, 0, 0, 0);
    nop(); nop(); nop();
    // youngest writer wins; x0 never forwards
    wr(7, 0); wr(7, 0);
    use1(7, 0, 0, 0);
    wr(0, 0);
    use1(0, 0, 0, 0);
    nop(); nop(); nop();
    // redirect beats the load-use stall
    wr(9, 1);
    use1(9, 1, 0, 0);
    nop(); nop(); nop();
    // hold freezes the stall state
    wr(10, 1);
    repeat (4) use1(10, 0, 1, 0);
    use1(10, 1, 1, 0);
    use1(10, 0, 0, 0); use1(10, 0, 0, 0); use1(10, 0, 0, 0);
    nop(); nop(); nop();
    // reset mid-stall
    wr(11, 1);
    use1(11, 0, 0, 0);
    use1(11, 1, 0, 1);
    use1(11, 0, 0, 0);
    // enough stalls to saturate the 4-bit counter
    for (int i = 0; i < 10; i++) begin
      wr(12, 1);
      use1(12, 0, 0, 0); use1(12, 0, 0, 0); use1(12, 0, 0, 0);
    end
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 199) == 0);
    end
    nop();
    @(negedge clk);
    #5;
    chk("drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
